// File: rtl/univ_shift_seq.sv
// Universal shift register with a two-state sequencer.
// A start in IDLE either completes at once (LOAD, NOP, zero-count shifts)
// or launches a burst of single-bit shifts, one per clock, in SHIFT.
module univ_shift_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic             S_DataIn,
  input  logic [WIDTH-1:0] P_DataIn,
  output logic [WIDTH-1:0] P_DataOut,
  output logic             S_DataOut,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ASR  = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // One-step shift result for the latched op; used on every SHIFT edge.
  logic [WIDTH-1:0] shift_data;
  logic             shift_out;

  // Opcodes 110/111 are NOPs, so only 001..101 launch a burst.
  logic             op_is_shift;

  // Decode whether the requested op is one of the shift family.
  always_comb begin
    op_is_shift = (op >= OP_SLL) && (op <= OP_ASR);
  end

  // Single-bit shift of the current register according to the latched op.
  always_comb begin
    shift_data = data_q;
    shift_out  = sout_q;
    case (op_q)
      OP_SLL: begin
        shift_data = {data_q[WIDTH-2:0], S_DataIn};
        shift_out  = data_q[WIDTH-1];
      end
      OP_SRL: begin
        shift_data = {S_DataIn, data_q[WIDTH-1:1]};
        shift_out  = data_q[0];
      end
      OP_ROL: begin
        shift_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        shift_out  = data_q[WIDTH-1];
      end
      OP_ROR: begin
        shift_data = {data_q[0], data_q[WIDTH-1:1]};
        shift_out  = data_q[0];
      end
      OP_ASR: begin
        shift_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        shift_out  = data_q[0];
      end
      default: begin
        shift_data = data_q;
        shift_out  = sout_q;
      end
    endcase
  end

  // Next-state logic: accept requests in IDLE, count down shifts in SHIFT.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sout_d  = sout_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_LOAD) begin
            data_d = P_DataIn;
            done_d = 1'b1;
          end else if (op_is_shift && (count != '0)) begin
            // Latch op and count; the first shift happens on the next edge.
            op_d    = op;
            cnt_d   = count;
            state_d = SHIFT;
          end else begin
            // NOP or zero-length shift: complete immediately, register untouched.
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        data_d = shift_data;
        sout_d = shift_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sout_q  <= 1'b0;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign P_DataOut = data_q;
  assign S_DataOut = sout_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Self-checking bench for univ_shift_seq (WIDTH=8) with a result scoreboard.
module tb_univ_shift_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] count;
  logic             S_DataIn;
  logic [WIDTH-1:0] P_DataIn;
  logic [WIDTH-1:0] P_DataOut;
  logic             S_DataOut;
  logic             busy;
  logic             done;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sout;
  } exp_t;

  exp_t sb_q[$];

  logic [WIDTH-1:0] model_reg;
  logic             model_sout;

  int n_cmp;
  int n_err;

  univ_shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .count     (count),
    .S_DataIn  (S_DataIn),
    .P_DataIn  (P_DataIn),
    .P_DataOut (P_DataOut),
    .S_DataOut (S_DataOut),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one accepted operation.
  task automatic model_apply(input logic [2:0] o, input logic [CNT_W-1:0] c,
                             input logic [WIDTH-1:0] pd, input logic si);
    if (o == 3'b000) begin
      model_reg = pd;
    end else if (o >= 3'b001 && o <= 3'b101) begin
      for (int k = 0; k < int'(c); k++) begin
        case (o)
          3'b001: begin model_sout = model_reg[7]; model_reg = {model_reg[6:0], si}; end
          3'b010: begin model_sout = model_reg[0]; model_reg = {si, model_reg[7:1]}; end
          3'b011: begin model_sout = model_reg[7]; model_reg = {model_reg[6:0], model_reg[7]}; end
          3'b100: begin model_sout = model_reg[0]; model_reg = {model_reg[0], model_reg[7:1]}; end
          default: begin model_sout = model_reg[0]; model_reg = {model_reg[7], model_reg[7:1]}; end
        endcase
      end
    end
  endtask

  // Issue one operation, wait for done, check busy length and scoreboard entry.
  task automatic do_op(input logic [2:0] o, input logic [CNT_W-1:0] c,
                       input logic [WIDTH-1:0] pd, input logic si, input string name);
    int   exp_busy;
    int   busy_cnt;
    bit   got;
    exp_t e;
    exp_busy = (o >= 3'b001 && o <= 3'b101) ? int'(c) : 0;
    model_apply(o, c, pd, si);
    sb_q.push_back('{data: model_reg, sout: model_sout});
    @(negedge clk);
    start = 1'b1; op = o; count = c; P_DataIn = pd; S_DataIn = si;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom);
    count = CNT_W'($urandom);
    P_DataIn = WIDTH'($urandom);
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      n_cmp++;
      if ((busy && done) !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy_done_overlap: got busy=%b done=%b required not both high", name, busy, done);
      end
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s done_timeout: got no done within 40 cycles required a done pulse", name);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if (busy_cnt !== exp_busy) begin
        n_err++;
        $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, exp_busy);
      end
      n_cmp++;
      if (P_DataOut !== e.data) begin
        n_err++;
        $display("FAIL %s p_dataout: got %h required %h", name, P_DataOut, e.data);
      end
      n_cmp++;
      if (S_DataOut !== e.sout) begin
        n_err++;
        $display("FAIL %s s_dataout: got %b required %b", name, S_DataOut, e.sout);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_width: got done=%b one cycle later required 0", name, done);
    end
    $display("op=%0d count=%0d pd=%h si=%b -> P=%h S=%b busy_cycles=%0d (%s)",
             o, c, pd, si, P_DataOut, S_DataOut, busy_cnt, name);
  endtask

  task automatic check_val(input logic [WIDTH-1:0] pv, input logic sv, input string name);
    n_cmp++;
    if (P_DataOut !== pv || S_DataOut !== sv) begin
      n_err++;
      $display("FAIL %s: got P=%h S=%b required P=%h S=%b", name, P_DataOut, S_DataOut, pv, sv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1; op = 3'b000; P_DataIn = 8'hFF; count = '0; S_DataIn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (P_DataOut !== 8'h00 || S_DataOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: got P=%h S=%b busy=%b done=%b required 00 0 0 0",
                 P_DataOut, S_DataOut, busy, done);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    model_reg = '0;
    model_sout = 1'b0;
    $display("reset: P=%h S=%b busy=%b done=%b", P_DataOut, S_DataOut, busy, done);
  endtask

  task automatic test_load();
    do_op(3'b000, 4'd0, 8'hCC, 1'b0, "load_cc");
    check_val(8'hCC, 1'b0, "load_cc_const");
  endtask

  task automatic test_sll();
    do_op(3'b001, 4'd3, 8'h00, 1'b1, "sll3");
    check_val(8'h67, 1'b0, "sll3_const");
  endtask

  task automatic test_rotate();
    do_op(3'b000, 4'd0, 8'hCC, 1'b0, "load_cc2");
    do_op(3'b100, 4'd8, 8'h00, 1'b1, "ror8");
    check_val(8'hCC, model_sout, "ror8_const");
    do_op(3'b011, 4'd9, 8'h00, 1'b0, "rol9");
    n_cmp++;
    if (P_DataOut !== 8'h99) begin
      n_err++;
      $display("FAIL rol9_const: got %h required 99", P_DataOut);
    end
  endtask

  task automatic test_asr_zero();
    do_op(3'b000, 4'd0, 8'h90, 1'b0, "load_90");
    do_op(3'b101, 4'd2, 8'h00, 1'b1, "asr2");
    check_val(8'hE4, 1'b0, "asr2_const");
    do_op(3'b010, 4'd0, 8'h00, 1'b1, "srl0");
    check_val(8'hE4, 1'b0, "srl0_const");
    do_op(3'b111, 4'd5, 8'h00, 1'b1, "nop");
  endtask

  task automatic test_reset_mid_burst();
    do_op(3'b000, 4'd0, 8'hA5, 1'b0, "load_a5");
    @(negedge clk);
    start = 1'b1; op = 3'b010; count = 4'd5; S_DataIn = 1'b1;
    @(posedge clk);
    #1;
    op = 3'b000; P_DataIn = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_busy: got %b required 1", busy);
    end
    @(negedge clk);
    check_val(8'hD2, 1'b1, "midrst_shift1");
    @(negedge clk);
    check_val(8'hE9, 1'b0, "midrst_shift2");
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (P_DataOut !== 8'h00 || S_DataOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_abandon: got P=%h S=%b busy=%b done=%b required 00 0 0 0",
               P_DataOut, S_DataOut, busy, done);
    end
    rst_n = 1'b1;
    start = 1'b1; op = 3'b000; P_DataIn = 8'h3C;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || P_DataOut !== 8'h3C) begin
      n_err++;
      $display("FAIL post_reset_start: got done=%b P=%h required done=1 P=3c", done, P_DataOut);
    end
    model_reg = 8'h3C;
    model_sout = 1'b0;
    $display("reset mid-burst: P=%h busy=%b done=%b", P_DataOut, busy, done);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; op = 3'b000; P_DataIn = 8'h0F; count = '0; S_DataIn = 1'b0;
    @(negedge clk);
    if (done === 1'b1) dones++;
    check_val(8'h0F, 1'b0, "b2b_load");
    op = 3'b001; count = 4'd1; S_DataIn = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b required busy=1 done=0", busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (i == 0) check_val(8'h1E, 1'b0, "b2b_sll");
    end
    n_cmp++;
    if (dones !== 2) begin
      n_err++;
      $display("FAIL b2b_done_count: got %0d required 2", dones);
    end
    $display("back-to-back: P=%h dones=%0d", P_DataOut, dones);
    model_reg = 8'h1E;
    model_sout = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_op(3'($urandom_range(0, 7)), CNT_W'($urandom_range(0, 11)),
            WIDTH'($urandom), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op = '0;
    count = '0;
    S_DataIn = 1'b0;
    P_DataIn = '0;
    test_reset();
    test_load();
    test_sll();
    test_rotate();
    test_asr_zero();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_seq.md
UNIV_SHIFT_SEQ -- requirements
Module: univ_shift_seq

Interface
REQ-001 Parameter: WIDTH, default 8; register width in bits; legal range 2 to 64.
REQ-002 Parameter: CNT_W, default clog2(WIDTH)+1; width of the shift-count port.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  operation request; sampled only while idle (busy=0).
REQ-006 Port: op  input  3  operation code, sampled with start.
REQ-007 Port: count  input  CNT_W  number of single-bit shifts, sampled with start.
REQ-008 Port: S_DataIn  input  1  serial input; sampled on every shift cycle of SLL/SRL.
REQ-009 Port: P_DataIn  input  WIDTH  parallel load data, sampled with start when op=LOAD.
REQ-010 Port: P_DataOut  output  WIDTH  current register contents (registered).
REQ-011 Port: S_DataOut  output  1  bit shifted out by the most recent shift (registered).
REQ-012 Port: busy  output  1  high while a shift burst is in progress.
REQ-013 Port: done  output  1  one-cycle pulse on completion of any accepted operation.

Function
REQ-014 Op encoding: 000 LOAD, 001 SLL, 010 SRL, 011 ROL, 100 ROR, 101 ASR; 110 and 111 are NOP.
REQ-015 The FSM has two states, IDLE and SHIFT; busy=1 exactly when the state is SHIFT.
REQ-016 IDLE, start=1, op=LOAD: P_DataOut<=P_DataIn at that edge; state stays IDLE; done=1 for the following cycle.
REQ-017 IDLE, start=1, op=NOP, or any shift op with count=0: register unchanged; state stays IDLE; done=1 for the following cycle.
REQ-018 IDLE, start=1, shift op, count>0: latch op and count; move to SHIFT; no shift on this edge.
REQ-019 In SHIFT, each edge performs exactly one single-bit shift and decrements the remaining count by one.
REQ-020 On the edge that performs the last shift: state returns to IDLE; done=1 for the following cycle.
REQ-021 Latency: start edge at cycle 0; shifts on edges 1..N; busy high for N cycles; done high in the cycle after edge N.
REQ-022 SLL: reg<={reg[WIDTH-2:0],S_DataIn}; S_DataOut<=old reg[WIDTH-1].
REQ-023 SRL: reg<={S_DataIn,reg[WIDTH-1:1]}; S_DataOut<=old reg[0].
REQ-024 ROL: reg<={reg[WIDTH-2:0],reg[WIDTH-1]}; S_DataOut<=old reg[WIDTH-1]; S_DataIn is ignored.
REQ-025 ROR: reg<={reg[0],reg[WIDTH-1:1]}; S_DataOut<=old reg[0]; S_DataIn is ignored.
REQ-026 ASR: reg<={reg[WIDTH-1],reg[WIDTH-1:1]}; S_DataOut<=old reg[0]; S_DataIn is ignored.
REQ-027 Counts greater than WIDTH are legal; every count performs exactly count shifts (for example, ROL by WIDTH restores the original value).
REQ-028 start while busy=1 is ignored; op, count and P_DataIn changes during SHIFT have no effect.
REQ-029 start asserted in the same cycle that done=1 (state IDLE) is accepted normally; back-to-back operations need no idle gap.
REQ-030 LOAD and NOP leave S_DataOut unchanged; S_DataOut changes only on shift edges.
REQ-031 done never lasts more than one cycle per accepted operation; busy and done are never high together.

Reset
REQ-032 rst_n=0 at a rising edge forces: P_DataOut=0, S_DataOut=0, busy=0, done=0, state IDLE, remaining count 0.
REQ-033 Reset has priority over start and over an in-progress burst; a burst interrupted by reset is abandoned with no done pulse.
REQ-034 The first start sampled with rst_n=1 after reset is accepted.

Verification
REQ-035 WIDTH=8. LOAD 0xCC -> P_DataOut=0xCC one edge later; done pulses once; busy stays 0.
REQ-036 From 0xCC: SLL, count=3, S_DataIn=1 -> busy high 3 cycles; P_DataOut=0x67; S_DataOut=0; done pulses once.
REQ-037 From 0xCC: ROR count=8, then ROL count=9 -> 0xCC after the first burst; 0x99 after the second.
REQ-038 From 0x90: ASR count=2 -> P_DataOut=0xE4, S_DataOut=0; then SRL count=0 -> done next cycle, value 0xE4 unchanged, busy never high.
REQ-039 SRL count=5 started; start with op=LOAD asserted during the burst -> LOAD ignored; rst_n=0 after 2 shifts -> next edge P_DataOut=0, busy=0, no done pulse; a start after reset is accepted.
REQ-040 Back-to-back: start held high with LOAD 0x0F, then SLL count=1, S_DataIn=0 -> P_DataOut=0x1E; two done pulses, one per accepted operation.
